// File: rtl/iddmm_result_sel.sv
// Final-subtraction result selector for the IDDMM Montgomery multiplier.
// Captures the raw (A) and subtracted (A-P) final-row word streams into two
// buffers, then replays the stream chosen by the core's sign flag, LSW first,
// over a valid/ready interface. Protocol violations raise a sticky ovf_err.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | nothing captured yet, waiting for the first word or cal_done
//   S_COLLECT| capturing words; waiting for both buffers full and cal_done
//   S_SEND   | replaying the selected buffer; all inputs are errors here
//
// N must be at least 2 so that the word index has a non-zero width.
module iddmm_result_sel #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_wr_en_a,
  input  logic [K-1:0]      fifo_wr_data_a,
  input  logic              fifo_wr_en_sub,
  input  logic [K-1:0]      fifo_wr_data_sub,
  input  logic              cal_done,
  input  logic              cal_sign,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [K-1:0]      result_data,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_last,
  output logic              busy,
  output logic              ovf_err,
  input  logic              err_clr
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND
  } state_t;

  state_t state_q, state_d;

  logic [K-1:0] buf_a_q [N];
  logic [K-1:0] buf_s_q [N];

  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]  cnt_s_q, cnt_s_d;
  logic              done_seen_q, done_seen_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

  logic              valid_q, valid_d;
  logic [K-1:0]      data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              wr_a_ok;
  logic              wr_s_ok;
  logic              err_set;
  logic [ADDR_W-1:0] rd_next;

  // A word is stored only outside SEND and while its buffer has room;
  // anything else is discarded and flagged below.
  assign wr_a_ok = fifo_wr_en_a   && (state_q != S_SEND) && (cnt_a_q != CNT_FULL);
  assign wr_s_ok = fifo_wr_en_sub && (state_q != S_SEND) && (cnt_s_q != CNT_FULL);
  assign rd_next = rd_idx_q + ADDR_W'(1);

  // Next-state, capture bookkeeping, output staging and error detection.
  always_comb begin
    state_d     = state_q;
    cnt_a_d     = cnt_a_q;
    cnt_s_d     = cnt_s_q;
    done_seen_d = done_seen_q;
    sel_d       = sel_q;
    rd_idx_d    = rd_idx_q;
    valid_d     = valid_q;
    data_d      = data_q;
    addr_d      = addr_q;
    last_d      = last_q;
    busy_d      = busy_q;
    err_set     = 1'b0;

    if (wr_a_ok) begin
      cnt_a_d = cnt_a_q + CNT_W'(1);
    end
    if (wr_s_ok) begin
      cnt_s_d = cnt_s_q + CNT_W'(1);
    end

    if (state_q == S_SEND) begin
      if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) begin
        err_set = 1'b1;
      end
    end else begin
      if (fifo_wr_en_a && (cnt_a_q == CNT_FULL)) begin
        err_set = 1'b1;
      end
      if (fifo_wr_en_sub && (cnt_s_q == CNT_FULL)) begin
        err_set = 1'b1;
      end
      if (cal_done) begin
        // The first completion owns the selection; a repeat is a protocol error.
        if (done_seen_q) begin
          err_set = 1'b1;
        end else begin
          done_seen_d = 1'b1;
          sel_d       = cal_sign;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) begin
          state_d = S_COLLECT;
          busy_d  = 1'b1;
        end
      end
      S_COLLECT: begin
        if (done_seen_q && (cnt_a_q == CNT_FULL) && (cnt_s_q == CNT_FULL)) begin
          state_d  = S_SEND;
          valid_d  = 1'b1;
          rd_idx_d = '0;
          addr_d   = '0;
          last_d   = (N == 1);
          data_d   = sel_q ? buf_s_q[0] : buf_a_q[0];
        end
      end
      S_SEND: begin
        if (valid_q && result_ready) begin
          if (rd_idx_q == IDX_LAST) begin
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            addr_d      = '0;
            busy_d      = 1'b0;
            cnt_a_d     = '0;
            cnt_s_d     = '0;
            done_seen_d = 1'b0;
            rd_idx_d    = '0;
          end else begin
            rd_idx_d = rd_next;
            addr_d   = rd_next;
            last_d   = (rd_next == IDX_LAST);
            data_d   = sel_q ? buf_s_q[rd_next] : buf_a_q[rd_next];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear so no violation is lost.
    if (err_set) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Word buffers; their contents are meaningless until filled, so no reset.
  always_ff @(posedge clk) begin
    if (wr_a_ok) begin
      buf_a_q[cnt_a_q[ADDR_W-1:0]] <= fifo_wr_data_a;
    end
    if (wr_s_ok) begin
      buf_s_q[cnt_s_q[ADDR_W-1:0]] <= fifo_wr_data_sub;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_a_q     <= '0;
      cnt_s_q     <= '0;
      done_seen_q <= 1'b0;
      sel_q       <= 1'b0;
      rd_idx_q    <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_a_q     <= cnt_a_d;
      cnt_s_q     <= cnt_s_d;
      done_seen_q <= done_seen_d;
      sel_q       <= sel_d;
      rd_idx_q    <= rd_idx_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign result_valid = valid_q;
  assign result_data  = data_q;
  assign result_addr  = addr_q;
  assign result_last  = last_q;
  assign busy         = busy_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Bench for iddmm_result_sel with K=8, N=4. The reference model is simply
// "the chosen list of words": expected output = sign ? S-list : A-list,
// replayed in order with addr = position and last on the final position.
module tb_iddmm_result_sel;
  localparam int K  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  typedef logic [K-1:0] warr_t [N];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_wr_en_a = 1'b0;
  logic [K-1:0]  fifo_wr_data_a = '0;
  logic          fifo_wr_en_sub = 1'b0;
  logic [K-1:0]  fifo_wr_data_sub = '0;
  logic          cal_done = 1'b0;
  logic          cal_sign = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [K-1:0]  result_data;
  logic [AW-1:0] result_addr;
  logic          result_last;
  logic          busy;
  logic          ovf_err;
  logic          err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  int early_valid;
  int unstable;
  int drain_cycles;
  bit timed_out;
  logic [K-1:0]  got_data [$];
  logic [AW-1:0] got_addr [$];
  logic          got_last [$];

  iddmm_result_sel #(.K(K), .N(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_wr_en_a    (fifo_wr_en_a),
    .fifo_wr_data_a  (fifo_wr_data_a),
    .fifo_wr_en_sub  (fifo_wr_en_sub),
    .fifo_wr_data_sub(fifo_wr_data_sub),
    .cal_done        (cal_done),
    .cal_sign        (cal_sign),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_data     (result_data),
    .result_addr     (result_addr),
    .result_last     (result_last),
    .busy            (busy),
    .ovf_err         (ovf_err),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_words(output warr_t w);
    for (int i = 0; i < N; i++) w[i] = K'($urandom);
  endtask

  // Feeds N words on each stream. done_at >= 0 pulses cal_done with that S
  // word, -1 pulses it one cycle after the last word, -2 never pulses it.
  // Returns #1 after the edge that completed the operation's inputs.
  task automatic push_words(input warr_t a, input warr_t s, input bit gap,
                            input int done_at, input bit sign);
    int ia = 0;
    int is = 0;
    early_valid = 0;
    while (ia < N || is < N) begin
      fifo_wr_en_a   = (ia < N) && (!gap || $urandom_range(0, 1) == 1);
      fifo_wr_en_sub = (is < N) && (!gap || $urandom_range(0, 1) == 1);
      cal_done       = fifo_wr_en_sub && (is == done_at);
      cal_sign       = sign;
      if (fifo_wr_en_a) begin
        fifo_wr_data_a = a[ia];
        ia++;
      end
      if (fifo_wr_en_sub) begin
        fifo_wr_data_sub = s[is];
        is++;
      end
      tick();
      if (result_valid) early_valid++;
    end
    fifo_wr_en_a   = 1'b0;
    fifo_wr_en_sub = 1'b0;
    cal_done       = 1'b0;
    if (done_at == -1) begin
      cal_done = 1'b1;
      cal_sign = sign;
      tick();
      cal_done = 1'b0;
      if (result_valid) early_valid++;
    end
  endtask

  // Consumes up to nhs words with ready asserted pct% of cycles, recording
  // each handshake and counting any change of a held (unaccepted) word.
  task automatic drain(input int pct, input int nhs, input int max_cycles);
    logic [K-1:0]  hd = '0;
    logic [AW-1:0] ha = '0;
    logic          hl = 1'b0;
    bit            hold = 1'b0;
    int            hs = 0;
    got_data.delete();
    got_addr.delete();
    got_last.delete();
    unstable     = 0;
    drain_cycles = 0;
    while (hs < nhs && drain_cycles < max_cycles) begin
      if (hold && (!result_valid || result_data !== hd || result_addr !== ha ||
                   result_last !== hl)) unstable++;
      hold = 1'b0;
      result_ready = ($urandom_range(0, 99) < pct);
      if (result_valid && result_ready) begin
        got_data.push_back(result_data);
        got_addr.push_back(result_addr);
        got_last.push_back(result_last);
        hs++;
      end else if (result_valid) begin
        hd = result_data;
        ha = result_addr;
        hl = result_last;
        hold = 1'b1;
      end
      tick();
      drain_cycles++;
    end
    result_ready = 1'b0;
    timed_out = (hs < nhs);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if (result_valid !== 1'b0 || result_data !== '0 || result_addr !== '0 ||
        result_last !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%0h a=%0d l=%b busy=%b ovf=%b want all 0",
               result_valid, result_data, result_addr, result_last, busy, ovf_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sign1();
    warr_t a, s;
    a = '{8'd10, 8'd11, 8'd12, 8'd13};
    s = '{8'd20, 8'd21, 8'd22, 8'd23};
    push_words(a, s, 1'b0, -1, 1'b1);
    total++;
    if (early_valid !== 0) begin
      bad++;
      $display("FAIL sign1_early_valid: got %0d cycles want 0", early_valid);
    end
    tick();
    total++;
    if (result_valid !== 1'b1 || result_data !== s[0] || busy !== 1'b1) begin
      bad++;
      $display("FAIL sign1_latency: got v=%b d=%0d busy=%b want v=1 d=%0d busy=1",
               result_valid, result_data, busy, s[0]);
    end
    drain(100, N, 50);
    total++;
    if (timed_out || got_data.size() != N || drain_cycles != N) begin
      bad++;
      $display("FAIL sign1_count: got %0d words in %0d cycles want %0d in %0d",
               got_data.size(), drain_cycles, N, N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      total++;
      if (got_data[i] !== s[i] || got_addr[i] !== AW'(i) || got_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL sign1_word%0d: got d=%0d a=%0d l=%b want d=%0d a=%0d l=%b",
                 i, got_data[i], got_addr[i], got_last[i], s[i], i, (i == N - 1));
      end
    end
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL sign1_end: got busy=%b v=%b want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_sign0_early_done();
    warr_t a, s;
    a = '{8'd10, 8'd11, 8'd12, 8'd13};
    s = '{8'd20, 8'd21, 8'd22, 8'd23};
    push_words(a, s, 1'b0, 2, 1'b0);
    total++;
    if (early_valid !== 0) begin
      bad++;
      $display("FAIL sign0_early_valid: got %0d cycles want 0", early_valid);
    end
    tick();
    total++;
    if (result_valid !== 1'b1 || result_data !== a[0]) begin
      bad++;
      $display("FAIL sign0_latency: got v=%b d=%0d want v=1 d=%0d",
               result_valid, result_data, a[0]);
    end
    drain(100, N, 50);
    total++;
    if (timed_out || got_data.size() != N) begin
      bad++;
      $display("FAIL sign0_count: got %0d want %0d", got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      total++;
      if (got_data[i] !== a[i] || got_addr[i] !== AW'(i) || got_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL sign0_word%0d: got d=%0d a=%0d l=%b want d=%0d a=%0d l=%b",
                 i, got_data[i], got_addr[i], got_last[i], a[i], i, (i == N - 1));
      end
    end
  endtask

  task automatic test_random_ready();
    warr_t a, s, exp;
    bit sign;
    for (int rep = 0; rep < 4; rep++) begin
      rand_words(a);
      rand_words(s);
      sign = 1'($urandom_range(0, 1));
      exp = sign ? s : a;
      push_words(a, s, 1'b1, -1, sign);
      tick();
      drain(50, N, 400);
      total++;
      if (timed_out || got_data.size() != N || unstable != 0) begin
        bad++;
        $display("FAIL rready_count: got %0d words unstable=%0d want %0d words unstable=0",
                 got_data.size(), unstable, N);
      end
      for (int i = 0; i < got_data.size() && i < N; i++) begin
        total++;
        if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i) || got_last[i] !== (i == N - 1)) begin
          bad++;
          $display("FAIL rready_word%0d: got d=%0h a=%0d l=%b want d=%0h a=%0d l=%b",
                   i, got_data[i], got_addr[i], got_last[i], exp[i], i, (i == N - 1));
        end
      end
    end
  endtask

  task automatic test_errors();
    warr_t a, s;
    rand_words(a);
    rand_words(s);
    push_words(a, s, 1'b1, -2, 1'b0);
    total++;
    if (ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pre: got ovf=%b want 0", ovf_err);
    end
    fifo_wr_en_a = 1'b1;
    fifo_wr_data_a = 8'hff;
    tick();
    fifo_wr_en_a = 1'b0;
    total++;
    if (ovf_err !== 1'b1 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_fifth_a: got ovf=%b v=%b want ovf=1 v=0", ovf_err, result_valid);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got ovf=%b want 0", ovf_err);
    end
    err_clr = 1'b1;
    fifo_wr_en_sub = 1'b1;
    fifo_wr_data_sub = 8'hee;
    tick();
    err_clr = 1'b0;
    fifo_wr_en_sub = 1'b0;
    total++;
    if (ovf_err !== 1'b1) begin
      bad++;
      $display("FAIL err_wins_clear: got ovf=%b want 1", ovf_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    cal_done = 1'b1;
    cal_sign = 1'b1;
    tick();
    total++;
    if (result_valid !== 1'b0 || ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL err_first_done: got v=%b ovf=%b want v=0 ovf=0", result_valid, ovf_err);
    end
    cal_sign = 1'b0;
    tick();
    cal_done = 1'b0;
    total++;
    if (ovf_err !== 1'b1 || result_valid !== 1'b1 || result_data !== s[0]) begin
      bad++;
      $display("FAIL err_second_done: got ovf=%b v=%b d=%0h want ovf=1 v=1 d=%0h",
               ovf_err, result_valid, result_data, s[0]);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    fifo_wr_en_a = 1'b1;
    fifo_wr_data_a = 8'h5a;
    tick();
    fifo_wr_en_a = 1'b0;
    total++;
    if (ovf_err !== 1'b1 || result_valid !== 1'b1 || result_data !== s[0] ||
        result_addr !== '0) begin
      bad++;
      $display("FAIL err_send_word: got ovf=%b v=%b d=%0h a=%0d want ovf=1 v=1 d=%0h a=0",
               ovf_err, result_valid, result_data, result_addr, s[0]);
    end
    drain(100, N, 50);
    total++;
    if (timed_out || got_data.size() != N) begin
      bad++;
      $display("FAIL err_count: got %0d want %0d", got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      total++;
      if (got_data[i] !== s[i] || got_addr[i] !== AW'(i)) begin
        bad++;
        $display("FAIL err_word%0d: got d=%0h a=%0d want d=%0h a=%0d",
                 i, got_data[i], got_addr[i], s[i], i);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_midop();
    warr_t a, s, exp;
    rand_words(a);
    rand_words(s);
    push_words(a, s, 1'b0, -1, 1'b0);
    tick();
    drain(100, 2, 20);
    rst_n = 1'b0;
    #2;
    total++;
    if (result_valid !== 1'b0 || result_data !== '0 || result_addr !== '0 ||
        result_last !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset: got v=%b d=%0h a=%0d l=%b busy=%b ovf=%b want all 0",
               result_valid, result_data, result_addr, result_last, busy, ovf_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rand_words(a);
    rand_words(s);
    exp = s;
    push_words(a, s, 1'b1, -1, 1'b1);
    tick();
    drain(100, N, 50);
    total++;
    if (timed_out || got_data.size() != N) begin
      bad++;
      $display("FAIL midop_count: got %0d want %0d", got_data.size(), N);
    end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      total++;
      if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i)) begin
        bad++;
        $display("FAIL midop_word%0d: got d=%0h a=%0d want d=%0h a=%0d",
                 i, got_data[i], got_addr[i], exp[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    warr_t a, s, exp;
    bit sign;
    for (int op = 0; op < 2; op++) begin
      rand_words(a);
      rand_words(s);
      sign = 1'($urandom_range(0, 1));
      exp = sign ? s : a;
      push_words(a, s, 1'b0, 3, sign);
      tick();
      drain(100, N, 50);
      total++;
      if (timed_out || got_data.size() != N || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_op%0d_count: got %0d words busy=%b want %0d busy=0",
                 op, got_data.size(), busy, N);
      end
      for (int i = 0; i < got_data.size() && i < N; i++) begin
        total++;
        if (got_data[i] !== exp[i] || got_addr[i] !== AW'(i) || got_last[i] !== (i == N - 1)) begin
          bad++;
          $display("FAIL b2b_op%0d_word%0d: got d=%0h a=%0d l=%b want d=%0h a=%0d",
                   op, i, got_data[i], got_addr[i], got_last[i], exp[i], i);
        end
      end
    end
    total++;
    if (ovf_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ovf: got %b want 0", ovf_err);
    end
  endtask

  initial begin
    test_reset();
    test_sign1();
    test_sign0_early_done();
    test_random_ready();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
